pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Supervises the system PLL. Runs on the PLL reference clock so it never depends on PLL outputs.
- Generates the PLL reset pulse and qualifies `locked` with a stability window.
- Releases one reset per output-clock domain in a fixed staggered order, then asserts `ready`.
- On lock loss or a relock request: re-asserts all domain resets and restarts the PLL. Per-domain reset synchronizers sit downstream and are outside this block.

Parameters:
- NUM_DOMAINS, 3: number of domain resets; released in order index 0 (outclk_0) first.
- PLL_RST_CYCLES, 64: refclk cycles `pll_rst` is held high per attempt.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before release.
- LOCK_TIMEOUT_CYCLES, 1048576: cycles waited in WAIT_LOCK before re-pulsing the PLL reset.
- STAGGER_CYCLES, 16: spacing between successive domain releases, and between the last release and `ready`.

Ports:
- refclk, input, 1: block clock, 50 MHz PLL reference.
- rst, input, 1: synchronous, active-high reset.
- locked, input, 1: PLL lock, asynchronous to refclk.
- relock_req, input, 1: single-cycle request to restart the PLL.
- pll_rst, output, 1: PLL reset, active high.
- dom_rst, output, NUM_DOMAINS: per-domain resets, active high.
- ready, output, 1: all domains released and lock held.
- lost_cnt, output, 8: saturating count of lock losses.
- state_o, output, 3: current FSM state, for debug.

Behaviour:
- Reset state: `rst`=1 sampled at an edge gives state PLL_RST, cnt=0, `pll_rst`=1, `dom_rst`=all ones, `ready`=0, `lost_cnt`=0, synchronizer flops=0.
- `rst` dominates every other input.
- Lock synchronizer: `locked` passes through a 2-flop synchronizer to give `locked_s`. `locked` sampled high at edge E is visible to the FSM at edge E+2.
- Counter: single 24-bit cycle counter, cleared on every state entry. All cycle parameters must be ≥1 and <2^24.
- State encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4.
- PLL_RST:
  - `pll_rst`=1, `dom_rst`=all ones, `ready`=0; `locked_s` ignored.
  - When cnt==PLL_RST_CYCLES-1: go to WAIT_LOCK and `pll_rst`=0. `pll_rst` therefore falls at the PLL_RST_CYCLES-th edge after entry.
- WAIT_LOCK:
  - `locked_s`=1: go to STABLE.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1: go to PLL_RST (retry). Not counted as a loss.
- STABLE:
  - `locked_s`=0: go to WAIT_LOCK. Not counted.
  - Else if cnt==LOCK_STABLE_CYCLES-1: go to RELEASE, `dom_rst[0]`=0, domain index idx=0.
  - Net result: `dom_rst[0]` falls at edge E+2+LOCK_STABLE_CYCLES.
- RELEASE:
  - Every STAGGER_CYCLES edges: idx increments and `dom_rst[idx]` is cleared.
  - STAGGER_CYCLES edges after the last domain is cleared: go to RUN, `ready`=1.
  - A released `dom_rst` bit stays low until a loss or relock.
- RUN: holds all outputs.
- Loss:
  - Trigger: `locked_s`=0 while in RELEASE or RUN.
  - Next edge: state PLL_RST, `pll_rst`=1, `dom_rst`=all ones, `ready`=0.
  - `lost_cnt` increments, saturating at 255.
- Relock:
  - Trigger: `relock_req`=1 in WAIT_LOCK, STABLE, RELEASE or RUN.
  - Same action as a loss, but `lost_cnt` is unchanged.
  - Ignored in PLL_RST.
- Loss and `relock_req` in the same cycle: treated as a loss; counter increments once.
- All outputs are registered. No combinational path from `locked` or `relock_req` to any output.
- `lost_cnt` clears only on `rst`.

Test Plan:
Parameters for all scenarios: NUM_DOMAINS=3, PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, STAGGER_CYCLES=2.
1. Basic bring-up.
   - Stimulus: deassert `rst` at edge 0; `locked` tied high from edge 0.
   - Required: `pll_rst` falls after edge 4; state 1 then 2.
   - Required: `dom_rst` goes 3'b111→3'b110→3'b100→3'b000, spaced 2 edges apart.
   - Required: `ready`=1 exactly 2 edges after `dom_rst`=0; `lost_cnt`=0.
2. Lock timeout.
   - Stimulus: `locked` held 0.
   - Required: `pll_rst` re-pulses high for 4 edges every 36 edges; `dom_rst` stays 3'b111; `lost_cnt`=0.
3. Glitch during STABLE.
   - Stimulus: `locked` drops for 1 cycle at stability count 5.
   - Required: FSM returns to WAIT_LOCK and the stability window restarts in full; no release; `lost_cnt`=0.
4. Loss during RUN.
   - Stimulus: `locked` falls.
   - Required: 3 edges later `dom_rst`=3'b111, `ready`=0, `pll_rst`=1, `lost_cnt`=1.
   - Required: full bring-up repeats once `locked` returns.
   - Stimulus: 300 further losses. Required: `lost_cnt` saturates at 255.
5. Relock and simultaneous events.
   - Stimulus: `relock_req` pulse in RUN. Required: full restart, `lost_cnt` unchanged.
   - Stimulus: `relock_req` together with `locked_s`=0 in RELEASE. Required: single increment.
   - Stimulus: `relock_req` in PLL_RST. Required: no effect.
6. Reset mid-operation.
   - Stimulus: `rst` asserted for 1 edge during RELEASE, with `dom_rst`=3'b110 and `lost_cnt`=7.
   - Required: next edge shows `dom_rst`=3'b111, `lost_cnt`=0, state 0, `pll_rst`=1.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Supervises the system PLL from its reference clock. The block pulses the
//   PLL reset and waits for `locked` to stay high for a stability window. It
//   then releases one reset per output-clock domain, one at a time in a fixed
//   order, and finally asserts `ready`.
//   A lock loss or a relock request pulls every domain back into reset and
//   restarts the PLL.
//
// Ports
//   refclk     : block clock (PLL reference, never a PLL output)
//   rst        : synchronous active-high reset
//   locked     : PLL lock, asynchronous to refclk
//   relock_req : single-cycle request to restart the PLL
//   pll_rst    : PLL reset, active high
//   dom_rst    : per-domain resets, active high; bit 0 is released first
//   ready      : all domains released and lock held
//   lost_cnt   : saturating count of lock losses (cleared only by rst)
//   state_o    : current FSM state, for debug
//
// Every cycle parameter must be in the range 1 .. 2^24-1.

module pll_reset_sequencer #(
  parameter int NUM_DOMAINS         = 3,
  parameter int PLL_RST_CYCLES      = 64,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int STAGGER_CYCLES      = 16
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   locked,
  input  logic                   relock_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] dom_rst,
  output logic                   ready,
  output logic [7:0]             lost_cnt,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam logic [23:0] PLL_RST_LAST = 24'(PLL_RST_CYCLES - 1);
  localparam logic [23:0] STABLE_LAST  = 24'(LOCK_STABLE_CYCLES - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [23:0] STAGGER_LAST = 24'(STAGGER_CYCLES - 1);

  state_t      state;
  logic [23:0] cnt;
  logic        sync_q1;
  logic        locked_s;
  logic        loss_evt;
  logic        relock_evt;

  // Two-flop synchronizer for the asynchronous lock indication.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync_q1  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q1  <= locked;
      locked_s <= sync_q1;
    end
  end

  // A loss only counts once the domains have started coming out of reset.
  // A lock drop in STABLE is a glitch and only restarts the stability window.
  assign loss_evt   = !locked_s && (state == RELEASE || state == RUN);
  assign relock_evt = relock_req && (state != PLL_RST);

  // NOTE: every register in this block updates with non-blocking (<=)
  // assignments, so each branch reads the pre-edge values of cnt, state and
  // dom_rst no matter the order in which the statements are written.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state    <= PLL_RST;
      cnt      <= '0;
      pll_rst  <= 1'b1;
      dom_rst  <= '1;
      ready    <= 1'b0;
      lost_cnt <= '0;
    end else if (loss_evt || relock_evt) begin
      // A loss takes precedence over a simultaneous relock, so the counter
      // increments only once.
      state   <= PLL_RST;
      cnt     <= '0;
      pll_rst <= 1'b1;
      dom_rst <= '1;
      ready   <= 1'b0;
      if (loss_evt && lost_cnt != 8'hFF) lost_cnt <= lost_cnt + 8'd1;
    end else begin
      cnt <= cnt + 24'd1;
      unique case (state)
        PLL_RST: begin
          if (cnt == PLL_RST_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            // Retry: pulse the PLL reset again. Not treated as a loss.
            state   <= PLL_RST;
            cnt     <= '0;
            pll_rst <= 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state   <= RELEASE;
            cnt     <= '0;
            dom_rst <= {NUM_DOMAINS{1'b1}} << 1;
          end
        end
        RELEASE: begin
          // Domains are released by shifting zeros in from bit 0. Once every
          // bit is clear, one more stagger interval leads to RUN.
          if (cnt == STAGGER_LAST) begin
            cnt <= '0;
            if (dom_rst == '0) begin
              state <= RUN;
              ready <= 1'b1;
            end else begin
              dom_rst <= dom_rst << 1;
            end
          end
        end
        RUN: begin
          cnt <= cnt;
        end
        default: begin
          state   <= PLL_RST;
          cnt     <= '0;
          pll_rst <= 1'b1;
          dom_rst <= '1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule
